fib_stack_engine: RTL and testbench
===================================

// Module: fib_stack_engine
// PURPOSE
//  Parametrised recursive Fibonacci engine: computes fib(n) via explicit call-frame stack
//  (fib(n)=fib(n-1)+fib(n-2), fib(0)=0, fib(1)=1). Generalises the fixed 8-bit controller/
//  datapath pair into one block with configurable operand/result width and stack depth,
//  start/done handshake, result saturation and stack-overflow detection.
// PARAMETERS
//  N_W    8   width of n operand and of frame n field
//  RES_W  16  width of result, partial-sum and return registers
//  DEPTH  32  stack depth in frames (frame = {n[N_W], phase[2], partial[RES_W]})
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      request; sampled only in IDLE
//  n_in     in   N_W    operand, captured on accepted start
//  busy     out  1      high in every state except IDLE
//  done     out  1      one-cycle pulse, result/err_* valid that cycle and held after
//  result   out  RES_W  fib(n_in), saturated; 0 on stack overflow
//  err_sat  out  1      sum exceeded 2^RES_W-1 during run (sticky to next start)
//  err_ovf  out  1      push attempted with stack full; run aborted
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, sp=0, busy=0, done=0, result=0, err_sat=0,
//   err_ovf=0, ret=0, cur frame=0. Reset mid-run aborts silently: no done pulse.
//  One state per cycle; FSM states IDLE, POP, EVAL, PUSHCH, DONE.
//  IDLE: start=1 -> stack[0]={n_in,0,0}, sp=1, err_sat=0, err_ovf=0 -> POP. start ignored
//   in all other states (no queueing).
//  POP: sp==0 -> result<=ret, DONE. Else cur<=stack[sp-1], sp<=sp-1 -> EVAL.
//  EVAL on cur={n,ph,p}:
//   n<=1 (leaf): ret<=n -> POP.
//   ph=0: push {n,1,0}, child<=n-1 -> PUSHCH.
//   ph=1: push {n,2,ret}, child<=n-2 -> PUSHCH.
//   ph=2: ret<=p+ret computed at RES_W+1 bits; carry out -> ret<=all ones, err_sat<=1;
//    -> POP.
//  PUSHCH: push {child,0,0} -> POP.
//  Any push with sp==DEPTH: no write, err_ovf<=1, result<=0 -> DONE directly.
//  Saturated ret propagates; further sums involving all-ones stay all-ones.
//  DONE: done=1 for exactly this cycle, busy=1 -> IDLE. result/err_* hold until next
//   accepted start.
//  Latency n_in in {0,1}: accept edge, POP, EVAL, POP, DONE => done high 4 cycles after
//   the cycle start was sampled. General n: bounded, ~3 cycles per frame visited.
//  Stack need: peak sp = n_in (n_in>=1); DEPTH>=n_in required to avoid err_ovf.
//  sp width = clog2(DEPTH+1); stack is a register array, no reset of contents required.
//  Simultaneous start + done: start is not sampled in DONE; sample again in IDLE next
//   cycle.
// TESTING
//  1. rst_n low mid-run of n=12 -> busy=0, done never pulses, result=0 immediately
//     (async).
//  2. n_in=0 and n_in=1 -> done exactly 4 cycles after start, result 0 / 1, err_*=0.
//  3. n_in=10, defaults -> result=55; n_in=24 -> result=46368; err_sat=0, err_ovf=0.
//  4. n_in=25, RES_W=16 -> result=65535, err_sat=1, err_ovf=0.
//  5. DEPTH=4, n_in=10 -> done pulse with err_ovf=1, result=0; next start n_in=3 ->
//     result=2, errs cleared.
//  6. start held high across run and pulsed in DONE -> exactly one run per IDLE
//     acceptance; back-to-back n=5,6 -> 5, 8.

Source files
------------

// File: rtl/fib_stack_engine.sv
// fib_stack_engine: recursive Fibonacci evaluated with an explicit call-frame stack.
// A frame is {n, phase, partial}. Phase 0 means the fib(n-1) call is still pending.
// Phase 1 means fib(n-2) is pending. Phase 2 means both children have returned and
// `partial` holds fib(n-1).
//
// Handshake: start is a request that is sampled only while the engine is in IDLE.
// Requests seen in any other state are dropped, not queued. done is a one-cycle pulse.
// result, err_sat and err_ovf are valid in the done cycle. They keep their values until
// the next accepted start. busy is high in every state except IDLE.
module fib_stack_engine #(
    parameter int N_W   = 8,
    parameter int RES_W = 16,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_W-1:0]   n_in,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             err_sat,
    output logic             err_ovf
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);

    typedef enum logic [2:0] {IDLE, POP, EVAL, PUSHCH, DONE} state_t;

    // state is left as a named internal signal so checkers can bind to it directly
    state_t state, state_nxt;

    logic [SP_W-1:0]  sp;
    logic [N_W-1:0]   stk_n  [DEPTH];
    logic [1:0]       stk_ph [DEPTH];
    logic [RES_W-1:0] stk_p  [DEPTH];

    logic [N_W-1:0]   cur_n;
    logic [1:0]       cur_ph;
    logic [RES_W-1:0] cur_p;
    logic [RES_W-1:0] ret;
    logic [N_W-1:0]   child;

    logic             push_req;
    logic             stack_full;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [N_W-1:0]   wr_n;
    logic [1:0]       wr_ph;
    logic [RES_W-1:0] wr_p;
    logic [RES_W:0]   sum;
    logic             is_leaf;

    assign stack_full = (sp == SP_FULL);
    assign rd_idx     = IDX_W'(sp - SP_W'(1));
    assign sum        = {1'b0, cur_p} + {1'b0, ret};
    assign is_leaf    = (cur_n <= N_W'(1));
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // Next-state decode; also selects which frame, if any, is written to the stack this cycle
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = IDX_W'(sp);
        wr_n      = '0;
        wr_ph     = 2'd0;
        wr_p      = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    wr_en     = 1'b1;
                    wr_idx    = '0;
                    wr_n      = n_in;
                    state_nxt = POP;
                end
            end
            POP: state_nxt = (sp == '0) ? DONE : EVAL;
            EVAL: begin
                if (is_leaf) begin
                    state_nxt = POP;
                end else if (cur_ph == 2'd0) begin
                    push_req  = 1'b1;
                    wr_n      = cur_n;
                    wr_ph     = 2'd1;
                    state_nxt = PUSHCH;
                end else if (cur_ph == 2'd1) begin
                    push_req  = 1'b1;
                    wr_n      = cur_n;
                    wr_ph     = 2'd2;
                    wr_p      = ret;
                    state_nxt = PUSHCH;
                end else begin
                    state_nxt = POP;
                end
            end
            PUSHCH: begin
                push_req  = 1'b1;
                wr_n      = child;
                state_nxt = POP;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // a push into a full stack aborts the run instead of writing
        if (push_req) begin
            if (stack_full) state_nxt = DONE;
            else            wr_en     = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Frame storage; contents are always written before they are read, so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stk_n[wr_idx]  <= wr_n;
            stk_ph[wr_idx] <= wr_ph;
            stk_p[wr_idx]  <= wr_p;
        end
    end

    // Datapath: stack pointer, current frame, return value, result and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp      <= '0;
            cur_n   <= '0;
            cur_ph  <= 2'd0;
            cur_p   <= '0;
            ret     <= '0;
            child   <= '0;
            result  <= '0;
            err_sat <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (push_req) begin
                if (stack_full) begin
                    err_ovf <= 1'b1;
                    result  <= '0;
                end else begin
                    sp <= sp + SP_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        sp      <= SP_W'(1);
                        err_sat <= 1'b0;
                        err_ovf <= 1'b0;
                    end
                end
                POP: begin
                    if (sp == '0) begin
                        result <= ret;
                    end else begin
                        cur_n  <= stk_n[rd_idx];
                        cur_ph <= stk_ph[rd_idx];
                        cur_p  <= stk_p[rd_idx];
                        sp     <= sp - SP_W'(1);
                    end
                end
                EVAL: begin
                    if (is_leaf) begin
                        ret <= RES_W'(cur_n);
                    end else if (cur_ph == 2'd0) begin
                        child <= cur_n - N_W'(1);
                    end else if (cur_ph == 2'd1) begin
                        child <= cur_n - N_W'(2);
                    end else if (sum[RES_W]) begin
                        // saturate: an all-ones operand keeps every later sum at all-ones
                        ret     <= '1;
                        err_sat <= 1'b1;
                    end else begin
                        ret <= sum[RES_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_stack_engine.sv
// Bench for fib_stack_engine: three instances
//   inst 0 = defaults (RES_W=16, DEPTH=32)
//   inst 1 = narrow result (RES_W=8) for saturation
//   inst 2 = shallow stack (DEPTH=4) for overflow
module tb_fib_stack_engine;

    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic start_a, start_s, start_o;
    logic [7:0] n_a, n_s, n_o;
    logic busy_a, busy_s, busy_o;
    logic done_a, done_s, done_o;
    logic [15:0] res_a, res_o;
    logic [7:0] res_s;
    logic es_a, es_s, es_o, eo_a, eo_s, eo_o;

    int n_tests = 0;
    int n_fail = 0;

    fib_stack_engine dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .n_in(n_a), .busy(busy_a),
        .done(done_a), .result(res_a), .err_sat(es_a), .err_ovf(eo_a));

    fib_stack_engine #(.N_W(8), .RES_W(8), .DEPTH(32)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .n_in(n_s), .busy(busy_s),
        .done(done_s), .result(res_s), .err_sat(es_s), .err_ovf(eo_s));

    fib_stack_engine #(.N_W(8), .RES_W(16), .DEPTH(4)) dut_o (
        .clk(clk), .rst_n(rst_n), .start(start_o), .n_in(n_o), .busy(busy_o),
        .done(done_o), .result(res_o), .err_sat(es_o), .err_ovf(eo_o));

    function automatic logic get_done(input int inst);
        case (inst)
            0:       return done_a;
            1:       return done_s;
            default: return done_o;
        endcase
    endfunction

    function automatic logic get_busy(input int inst);
        case (inst)
            0:       return busy_a;
            1:       return busy_s;
            default: return busy_o;
        endcase
    endfunction

    function automatic logic [15:0] get_res(input int inst);
        case (inst)
            0:       return res_a;
            1:       return {8'h00, res_s};
            default: return res_o;
        endcase
    endfunction

    function automatic logic get_es(input int inst);
        case (inst)
            0:       return es_a;
            1:       return es_s;
            default: return es_o;
        endcase
    endfunction

    function automatic logic get_eo(input int inst);
        case (inst)
            0:       return eo_a;
            1:       return eo_s;
            default: return eo_o;
        endcase
    endfunction

    task automatic set_start(input int inst, input logic v, input logic [7:0] n);
        case (inst)
            0:       begin start_a = v; n_a = n; end
            1:       begin start_s = v; n_s = n; end
            default: begin start_o = v; n_o = n; end
        endcase
    endtask

    // Reference model: exact Fibonacci with a cap; latency from counting frames
    // (each leaf call takes 2 cycles, each internal call 8, plus accept and final pop).
    function automatic void model(input int n, input int res_w, input int depth,
                                  output logic [15:0] res, output logic es,
                                  output logic eo, output int lat);
        longint unsigned a = 0;
        longint unsigned b = 1;
        longint unsigned t;
        longint unsigned maxv;
        maxv = (64'd1 << res_w) - 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        eo  = (n >= 1) && (n > depth);
        es  = !eo && (a > maxv);
        res = eo ? 16'd0 : ((a > maxv) ? 16'(maxv) : 16'(a));
        lat = int'(2 * b + 8 * (b - 1) + 2);
    endfunction

    // Driver: one-cycle start pulse, then wait (bounded) for done; returns at the done cycle
    task automatic run_job(input int inst, input int n, output logic [15:0] res,
                           output logic es, output logic eo, output int lat);
        @(negedge clk);
        set_start(inst, 1'b1, 8'(n));
        @(negedge clk);
        set_start(inst, 1'b0, 8'(n));
        lat = 1;
        while (!get_done(inst) && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        if (!get_done(inst)) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout inst%0d n=%0d: done not seen within %0d cycles", inst, n, LIMIT);
        end
        res = get_res(inst);
        es  = get_es(inst);
        eo  = get_eo(inst);
    endtask

    task automatic test_reset();
        logic [15:0] r;
        logic es, eo;
        int lat;
        bit saw;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
        n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_a); end
        n_tests++; if (res_a !== 16'd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", res_a); end
        n_tests++; if (es_a !== 1'b0 || eo_a !== 1'b0) begin n_fail++; $display("FAIL reset_errs got %b%b want 00", es_a, eo_a); end
        rst_n = 1'b1;
        run_job(0, 3, r, es, eo, lat);
        n_tests++; if (r !== 16'd2) begin n_fail++; $display("FAIL pre_reset_run result got %0d want 2", r); end
        @(negedge clk);
        set_start(0, 1'b1, 8'd12);
        @(negedge clk);
        set_start(0, 1'b0, 8'd12);
        repeat (20) @(negedge clk);
        n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got %b want 1", busy_a); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got %b want 0", busy_a); end
        n_tests++; if (res_a !== 16'd0) begin n_fail++; $display("FAIL async_reset_result got %0d want 0", res_a); end
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || busy_a !== 1'b0) saw = 1'b1;
        end
        n_tests++; if (saw) begin n_fail++; $display("FAIL reset_abort_silent got activity want none"); end
    endtask

    task automatic test_small();
        logic [15:0] r;
        logic es, eo;
        int lat;
        for (int n = 0; n < 2; n++) begin
            run_job(0, n, r, es, eo, lat);
            n_tests++; if (r !== 16'(n)) begin n_fail++; $display("FAIL small_result n=%0d got %0d want %0d", n, r, n); end
            n_tests++; if (lat != 4) begin n_fail++; $display("FAIL small_latency n=%0d got %0d want 4", n, lat); end
            n_tests++; if (es !== 1'b0 || eo !== 1'b0) begin n_fail++; $display("FAIL small_errs n=%0d got %b%b want 00", n, es, eo); end
            @(negedge clk);
            n_tests++; if (done_a !== 1'b0 || busy_a !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle n=%0d got done=%b busy=%b want 0 0", n, done_a, busy_a); end
        end
    endtask

    task automatic test_known();
        int ns [2] = '{10, 15};
        logic [15:0] want [2] = '{16'd55, 16'd610};
        logic [15:0] r, mr;
        logic es, eo, mes, meo;
        int lat, mlat;
        for (int i = 0; i < 2; i++) begin
            run_job(0, ns[i], r, es, eo, lat);
            model(ns[i], 16, 32, mr, mes, meo, mlat);
            n_tests++; if (r !== want[i]) begin n_fail++; $display("FAIL known_result n=%0d got %0d want %0d", ns[i], r, want[i]); end
            n_tests++; if (es !== 1'b0 || eo !== 1'b0) begin n_fail++; $display("FAIL known_errs n=%0d got %b%b want 00", ns[i], es, eo); end
            n_tests++; if (lat != mlat) begin n_fail++; $display("FAIL known_latency n=%0d got %0d want %0d", ns[i], lat, mlat); end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] r;
        logic es, eo;
        int lat;
        run_job(1, 13, r, es, eo, lat);
        n_tests++; if (r !== 16'd233 || es !== 1'b0) begin n_fail++; $display("FAIL sat_edge got %0d es=%b want 233 es=0", r, es); end
        run_job(1, 14, r, es, eo, lat);
        n_tests++; if (r !== 16'd255) begin n_fail++; $display("FAIL sat_result got %0d want 255", r); end
        n_tests++; if (es !== 1'b1 || eo !== 1'b0) begin n_fail++; $display("FAIL sat_flags got es=%b eo=%b want 1 0", es, eo); end
        repeat (3) @(negedge clk);
        n_tests++; if (es_s !== 1'b1 || res_s !== 8'd255) begin n_fail++; $display("FAIL sat_hold got es=%b res=%0d want 1 255", es_s, res_s); end
        run_job(1, 5, r, es, eo, lat);
        n_tests++; if (r !== 16'd5 || es !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %0d es=%b want 5 es=0", r, es); end
    endtask

    task automatic test_overflow();
        logic [15:0] r;
        logic es, eo;
        int lat;
        run_job(2, 4, r, es, eo, lat);
        n_tests++; if (r !== 16'd3 || eo !== 1'b0) begin n_fail++; $display("FAIL ovf_boundary got %0d eo=%b want 3 eo=0", r, eo); end
        run_job(2, 5, r, es, eo, lat);
        n_tests++; if (r !== 16'd0 || eo !== 1'b1) begin n_fail++; $display("FAIL ovf_n5 got %0d eo=%b want 0 eo=1", r, eo); end
        run_job(2, 10, r, es, eo, lat);
        n_tests++; if (r !== 16'd0 || eo !== 1'b1) begin n_fail++; $display("FAIL ovf_n10 got %0d eo=%b want 0 eo=1", r, eo); end
        run_job(2, 3, r, es, eo, lat);
        n_tests++; if (r !== 16'd2 || eo !== 1'b0 || es !== 1'b0) begin n_fail++; $display("FAIL ovf_recover got %0d es=%b eo=%b want 2 0 0", r, es, eo); end
    endtask

    task automatic test_random();
        logic [15:0] r, mr;
        logic es, eo, mes, meo;
        int lat, mlat, inst, n, rw, dp;
        for (int i = 0; i < 10; i++) begin
            inst = int'($urandom_range(0, 2));
            case (inst)
                0:       begin n = int'($urandom_range(0, 11)); rw = 16; dp = 32; end
                1:       begin n = int'($urandom_range(0, 13)); rw = 8;  dp = 32; end
                default: begin n = int'($urandom_range(0, 7));  rw = 16; dp = 4;  end
            endcase
            run_job(inst, n, r, es, eo, lat);
            model(n, rw, dp, mr, mes, meo, mlat);
            n_tests++; if (r !== mr) begin n_fail++; $display("FAIL rand_result inst%0d n=%0d got %0d want %0d", inst, n, r, mr); end
            n_tests++; if (es !== mes || eo !== meo) begin n_fail++; $display("FAIL rand_flags inst%0d n=%0d got %b%b want %b%b", inst, n, es, eo, mes, meo); end
            if (!meo) begin
                n_tests++; if (lat != mlat) begin n_fail++; $display("FAIL rand_latency inst%0d n=%0d got %0d want %0d", inst, n, lat, mlat); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        bit saw;
        logic [15:0] r;
        logic es, eo;
        int lat;
        // start held high: each pass through IDLE accepts exactly one run
        @(negedge clk);
        set_start(0, 1'b1, 8'd5);
        cnt = 0;
        while (!done_a && cnt < LIMIT) begin @(negedge clk); cnt++; end
        n_tests++; if (done_a !== 1'b1 || res_a !== 16'd5) begin n_fail++; $display("FAIL b2b_first got done=%b res=%0d want 1 5", done_a, res_a); end
        set_start(0, 1'b1, 8'd6);
        @(negedge clk);
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap got busy=%b want 0", busy_a); end
        cnt = 0;
        while (!done_a && cnt < LIMIT) begin @(negedge clk); cnt++; end
        n_tests++; if (done_a !== 1'b1 || res_a !== 16'd8) begin n_fail++; $display("FAIL b2b_second got done=%b res=%0d want 1 8", done_a, res_a); end
        set_start(0, 1'b0, 8'd6);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (busy_a !== 1'b0) saw = 1'b1; end
        n_tests++; if (saw) begin n_fail++; $display("FAIL b2b_no_extra_run got busy want idle"); end
        // start pulsed only during DONE is ignored
        run_job(0, 5, r, es, eo, lat);
        set_start(0, 1'b1, 8'd6);
        @(negedge clk);
        set_start(0, 1'b0, 8'd6);
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (busy_a !== 1'b0) saw = 1'b1; end
        n_tests++; if (saw || res_a !== 16'd5) begin n_fail++; $display("FAIL start_in_done_ignored got busy_seen=%b res=%0d want 0 5", saw, res_a); end
    endtask

    initial begin
        start_a = 1'b0; start_s = 1'b0; start_o = 1'b0;
        n_a = '0; n_s = '0; n_o = '0;
        test_reset();
        test_small();
        test_known();
        test_saturate();
        test_overflow();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
